// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - 3-byte UART command receiver with 1-byte response transmitter
// RX: cmd, data[15:8], data[7:0] frames held behind a cmd_rdy handshake. TX: independent response shifter.
module uart_cmd_responder #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err,
  output logic        ovr
);

  localparam logic [31:0] LP_BIT_LAST  = 32'(BAUD_DIV - 1);
  localparam logic [31:0] LP_HALF_LAST = 32'(BAUD_DIV / 2 - 1);
  localparam logic [31:0] LP_TO_LAST   = 32'(TIMEOUT_BITS * BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      r_rx_state;
  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  logic [31:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic [1:0]  r_idx;
  logic [7:0]  r_sh_cmd, r_sh_hi;
  logic [31:0] r_to_cnt;
  logic [7:0]  r_cmd;
  logic [15:0] r_data;
  logic        r_cmd_rdy, r_frm_err, r_ovr;

  state_t      r_tx_state;
  logic [31:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_tx, r_tx_busy, r_resp_sent;

  logic        w_rx_fall;
  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

  // Sync flops reset to the idle-high level so leaving reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= S_IDLE;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_idx      <= '0;
      r_sh_cmd   <= '0;
      r_sh_hi    <= '0;
      r_to_cnt   <= '0;
      r_cmd      <= '0;
      r_data     <= '0;
      r_cmd_rdy  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_rx_s1   <= RX;
      r_rx_s2   <= r_rx_s1;
      r_rx_s3   <= r_rx_s2;
      r_frm_err <= 1'b0;
      r_ovr     <= 1'b0;
      if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;

      if (r_rx_state == S_IDLE && r_idx != 2'd0) begin
        if (r_to_cnt == LP_TO_LAST) begin
          r_to_cnt  <= '0;
          r_idx     <= 2'd0;
          r_frm_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 32'd1;
        end
      end else begin
        r_to_cnt <= '0;
      end

      case (r_rx_state)
        S_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= S_START;
            r_rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_rx_cnt == LP_HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 32'd1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == LP_BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 32'd1;
          end
        end
        default: begin
          if (r_rx_cnt == LP_BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
            if (!r_rx_s2) begin
              r_frm_err <= 1'b1;
              r_idx     <= 2'd0;
            end else begin
              case (r_idx)
                2'd0: begin
                  r_sh_cmd <= r_rx_shift;
                  r_idx    <= 2'd1;
                end
                2'd1: begin
                  r_sh_hi <= r_rx_shift;
                  r_idx   <= 2'd2;
                end
                default: begin
                  // Commit overrides a same-cycle clear, and a cleared frame is not an overrun.
                  r_cmd     <= r_sh_cmd;
                  r_data    <= {r_sh_hi, r_rx_shift};
                  r_cmd_rdy <= 1'b1;
                  r_ovr     <= r_cmd_rdy & ~clr_cmd_rdy;
                  r_idx     <= 2'd0;
                end
              endcase
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state  <= S_IDLE;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_shift  <= '0;
      r_tx        <= 1'b1;
      r_tx_busy   <= 1'b0;
      r_resp_sent <= 1'b0;
    end else begin
      r_resp_sent <= 1'b0;
      case (r_tx_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (send_resp) begin
            r_tx_shift <= resp;
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == LP_BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 32'd1;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == LP_BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 32'd1;
          end
        end
        default: begin
          if (r_tx_cnt == LP_BIT_LAST) begin
            r_tx_cnt    <= '0;
            r_resp_sent <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_tx_state  <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  assign TX        = r_tx;
  assign cmd       = r_cmd;
  assign data      = r_data;
  assign cmd_rdy   = r_cmd_rdy;
  assign resp_sent = r_resp_sent;
  assign tx_busy   = r_tx_busy;
  assign frm_err   = r_frm_err;
  assign ovr       = r_ovr;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - directed bench for uart_cmd_responder
// Short baud divisor keeps frames at 160 cycles; pulse outputs are tallied by a monitor.
module tb_uart_cmd_responder;

  localparam int BD  = 16;
  localparam int TOB = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, resp_sent, tx_busy, frm_err, ovr;
  logic [7:0]  cmd;
  logic [15:0] data;

  int n_checks = 0;
  int n_fail   = 0;
  int frm_cnt  = 0;
  int ovr_cnt  = 0;
  int sent_cnt = 0;

  uart_cmd_responder #(.BAUD_DIV(BD), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent), .tx_busy(tx_busy),
    .frm_err(frm_err), .ovr(ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (frm_err)   frm_cnt++;
    if (ovr)       ovr_cnt++;
    if (resp_sent) sent_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_body(input logic [7:0] b);
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
  endtask

  task automatic send_stop(input logic v);
    RX = v;
    tick(BD);
    RX = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_body(b);
    send_stop(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [15:0] d);
    send_byte(c);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    n_checks++;
    if ({TX, tx_busy, cmd_rdy, resp_sent, frm_err, ovr} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 100000", {TX, tx_busy, cmd_rdy, resp_sent, frm_err, ovr});
    end
    n_checks++;
    if ({cmd, data} !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_cmd_data: got %h expected 000000", {cmd, data});
    end
  endtask

  task automatic test_frame();
    int f0;
    f0 = frm_cnt;
    send_byte(8'h05);
    send_byte(8'h00);
    send_body(8'hFF);
    n_checks++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_early_rdy: got %b expected 0", cmd_rdy);
    end
    send_stop(1'b1);
    n_checks++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_rdy: got %b expected 1", cmd_rdy);
    end
    n_checks++;
    if ({cmd, data} !== 24'h0500FF) begin
      n_fail++;
      $display("FAIL frame_value: got %h expected 0500ff", {cmd, data});
    end
    pulse_clr();
    n_checks++;
    if (cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_clr: got %b expected 0", cmd_rdy);
    end
    n_checks++;
    if ({cmd, data} !== 24'h0500FF || frm_cnt != f0) begin
      n_fail++;
      $display("FAIL frame_hold: got %h frm_err=%0d expected 0500ff frm_err=0", {cmd, data}, frm_cnt - f0);
    end
  endtask

  task automatic test_response();
    logic exp_bits [0:9];
    int   s0;
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    s0 = sent_cnt;
    resp = 8'hA5;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    for (int c = 0; c < 10 * BD + 2; c++) begin
      if (c == 0) begin
        n_checks++;
        if (TX !== 1'b0 || tx_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL resp_first_cycle: got TX=%b busy=%b expected TX=0 busy=1", TX, tx_busy);
        end
      end
      if (c % BD == BD / 2 && c < 10 * BD) begin
        n_checks++;
        if (TX !== exp_bits[c / BD]) begin
          n_fail++;
          $display("FAIL resp_bit%0d: got %b expected %b", c / BD, TX, exp_bits[c / BD]);
        end
      end
      if (c == 3 * BD) begin
        resp = 8'h00;
        send_resp = 1'b1;
      end
      if (c == 3 * BD + 1) send_resp = 1'b0;
      if (c == 10 * BD - 1) begin
        n_checks++;
        if (resp_sent !== 1'b0 || tx_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL resp_before_end: got sent=%b busy=%b expected sent=0 busy=1", resp_sent, tx_busy);
        end
      end
      if (c == 10 * BD) begin
        n_checks++;
        if (resp_sent !== 1'b1 || tx_busy !== 1'b0 || TX !== 1'b1) begin
          n_fail++;
          $display("FAIL resp_end: got sent=%b busy=%b TX=%b expected 1 0 1", resp_sent, tx_busy, TX);
        end
      end
      if (c == 10 * BD + 1) begin
        n_checks++;
        if (resp_sent !== 1'b0) begin
          n_fail++;
          $display("FAIL resp_pulse_width: got %b expected 0", resp_sent);
        end
      end
      tick(1);
    end
    n_checks++;
    if (sent_cnt - s0 != 1) begin
      n_fail++;
      $display("FAIL resp_count: got %0d expected 1", sent_cnt - s0);
    end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    send_frame(8'h02, 16'h0100);
    tick(2);
    n_checks++;
    if (cmd_rdy !== 1'b1 || {cmd, data} !== 24'h020100 || ovr_cnt != o0) begin
      n_fail++;
      $display("FAIL ovr_first: got rdy=%b val=%h ovr=%0d expected 1 020100 0", cmd_rdy, {cmd, data}, ovr_cnt - o0);
    end
    send_frame(8'h03, 16'hFF80);
    tick(2);
    n_checks++;
    if (ovr_cnt - o0 != 1) begin
      n_fail++;
      $display("FAIL ovr_count: got %0d expected 1", ovr_cnt - o0);
    end
    n_checks++;
    if (cmd_rdy !== 1'b1 || {cmd, data} !== 24'h03FF80) begin
      n_fail++;
      $display("FAIL ovr_value: got rdy=%b val=%h expected 1 03ff80", cmd_rdy, {cmd, data});
    end
    pulse_clr();
  endtask

  task automatic test_frame_error();
    int f0;
    f0 = frm_cnt;
    send_byte(8'h11);
    send_body(8'h22);
    send_stop(1'b0);
    tick(2 * BD);
    n_checks++;
    if (frm_cnt - f0 != 1 || cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_pulse: got frm_err=%0d rdy=%b expected 1 0", frm_cnt - f0, cmd_rdy);
    end
    send_frame(8'h04, 16'h0080);
    tick(2);
    n_checks++;
    if (cmd_rdy !== 1'b1 || {cmd, data} !== 24'h040080 || frm_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL ferr_recover: got rdy=%b val=%h frm_err=%0d expected 1 040080 1", cmd_rdy, {cmd, data}, frm_cnt - f0);
    end
    pulse_clr();
  endtask

  task automatic test_timeout();
    int f0;
    f0 = frm_cnt;
    send_byte(8'h06);
    tick(19 * BD);
    n_checks++;
    if (frm_cnt != f0) begin
      n_fail++;
      $display("FAIL timeout_early: got %0d expected 0", frm_cnt - f0);
    end
    tick(2 * BD);
    n_checks++;
    if (frm_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL timeout_pulse: got %0d expected 1", frm_cnt - f0);
    end
    tick(4 * BD);
    send_frame(8'h08, 16'h0000);
    tick(2);
    n_checks++;
    if (cmd_rdy !== 1'b1 || {cmd, data} !== 24'h080000 || frm_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL timeout_frame: got rdy=%b val=%h frm_err=%0d expected 1 080000 1", cmd_rdy, {cmd, data}, frm_cnt - f0);
    end
    pulse_clr();
  endtask

  task automatic test_glitch();
    int f0;
    f0 = frm_cnt;
    RX = 1'b0;
    tick(3);
    RX = 1'b1;
    tick(2 * BD);
    send_frame(8'h09, 16'h1234);
    tick(2);
    n_checks++;
    if (cmd_rdy !== 1'b1 || {cmd, data} !== 24'h091234 || frm_cnt != f0) begin
      n_fail++;
      $display("FAIL glitch_frame: got rdy=%b val=%h frm_err=%0d expected 1 091234 0", cmd_rdy, {cmd, data}, frm_cnt - f0);
    end
    pulse_clr();
  endtask

  task automatic test_reset_midop();
    int s0;
    send_byte(8'h55);
    resp = 8'h3C;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    s0 = sent_cnt;
    tick(5 * BD + BD / 2);
    n_checks++;
    if (tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy: got %b expected 1", tx_busy);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++;
    if (TX !== 1'b1 || tx_busy !== 1'b0 || cmd_rdy !== 1'b0 || {cmd, data} !== 24'h000000) begin
      n_fail++;
      $display("FAIL midop_reset: got TX=%b busy=%b rdy=%b val=%h expected 1 0 0 000000", TX, tx_busy, cmd_rdy, {cmd, data});
    end
    tick(10 * BD);
    n_checks++;
    if (sent_cnt != s0 || TX !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_no_sent: got sent=%0d TX=%b expected 0 1", sent_cnt - s0, TX);
    end
    send_frame(8'h07, 16'h0000);
    tick(2);
    n_checks++;
    if (cmd_rdy !== 1'b1 || {cmd, data} !== 24'h070000) begin
      n_fail++;
      $display("FAIL midop_frame: got rdy=%b val=%h expected 1 070000", cmd_rdy, {cmd, data});
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_response();
    test_overrun();
    test_frame_error();
    test_timeout();
    test_glitch();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
